// File: rtl/uart_note_rx.sv
// 8N1 UART receiver turning ASCII '0'..'7' into 3-bit note codes via a FWFT FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of the line.
module uart_note_rx #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [2:0] note,
  output logic       note_valid,
  input  logic       note_ready,
  output logic       frame_err,
  output logic       code_err,
  output logic       overflow
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [AW:0]   FULL_N  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          rx_m, rx_s;
  logic          samp;
  logic          push, fe_n, ce_n, ovf_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // rx_h[0] is rx_s one cycle ago, rx_h[1] two cycles ago
  logic [1:0] rx_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_h <= 2'b11;
    else     rx_h <= {rx_h[0], rx_s};
  end

  assign samp = (rx_h[1] & rx_h[0]) |
                (rx_h[1] & rx_s) |
                (rx_h[0] & rx_s);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    fe_n      = 1'b0;
    ce_n      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = samp ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CPB_M1) begin
          cnt_n            = '0;
          shift_n[bit_idx] = samp;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CPB_M1) begin
          cnt_n = '0;
          if (samp) begin
            state_n = IDLE;
            if (shift[7:3] == 5'b00110) push = 1'b1;
            else                        ce_n = 1'b1;
          end else begin
            state_n = BREAK;
            fe_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [2:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  assign full       = (count == FULL_N);
  assign note_valid = (count != '0);
  assign pop        = note_valid & note_ready;
  // a pop frees the head slot on the same edge, so a full FIFO still accepts
  assign wr_en      = push & (~full | pop);
  assign ovf_n      = push & full & ~pop;
  assign note       = note_valid ? mem[rd_ptr] : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 3'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift[2:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW+1)'(1);
      else if (!wr_en && pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      code_err  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= fe_n;
      code_err  <= ce_n;
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_uart_note_rx.sv
// Scoreboard bench for uart_note_rx: stimulus queues expected notes and
// error pulses, an independent monitor pops and compares them.
module tb_uart_note_rx;

  localparam int CPB   = 104;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       note_ready = 1'b0;
  logic [2:0] note;
  logic       note_valid;
  logic       frame_err, code_err, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_notes[$];
  int exp_errs[$];
  int rdy_mode = 0;

  uart_note_rx #(
    .CLK_FREQ(12_000_000),
    .BAUD(115_200),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .note(note),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .frame_err(frame_err),
    .code_err(code_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Reference model: error kinds 1=frame, 2=code, 3=overflow
  task automatic expect_frame(logic [7:0] b, bit stop_ok);
    if (!stop_ok)
      exp_errs.push_back(1);
    else if (b >= 8'h30 && b <= 8'h37) begin
      if (exp_notes.size() >= DEPTH) exp_errs.push_back(3);
      else exp_notes.push_back(int'(b) - 'h30);
    end else
      exp_errs.push_back(2);
  endtask

  task automatic line(logic v, int n);
    #1 rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(logic [7:0] b, bit stop_ok);
    expect_frame(b, stop_ok);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop_ok, CPB);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       note_ready = 1'b0;
        1:       note_ready = 1'b1;
        default: note_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    int np, kind, prev_np;
    prev_np = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        np = int'(frame_err) + int'(code_err) + int'(overflow);
        if (np > 1) check("one_pulse", np, 1);
        if (np != 0 && prev_np != 0) check("pulse_width", 2, 1);
        if (np == 1) begin
          kind = frame_err ? 1 : (code_err ? 2 : 3);
          if (exp_errs.size() == 0) check("unexpected_err", kind, 0);
          else check("err_kind", kind, exp_errs.pop_front());
        end
        if (note_valid && note_ready) begin
          if (exp_notes.size() == 0) check("unexpected_note", int'(note), -1);
          else check("note", int'(note), exp_notes.pop_front());
        end
        prev_np = np;
      end else begin
        prev_np = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    bit st;
    int r;
    int digs[5] = '{1, 2, 5, 7, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_note_valid", int'(note_valid), 0);
    check("rst_note", int'(note), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single '3' with consumer ready: appears inside stop bit, popped at once
    rdy_mode = 1;
    line(1'b1, 20);
    fork
      send_frame(8'h33, 1'b1);
      begin
        lat = 0;
        while (!note_valid && lat < 1200) begin
          @(negedge clk);
          lat++;
        end
        check("latency_in_stop_bit", int'(lat >= 936 && lat <= 1040), 1);
        @(negedge clk);
        check("pop_next_edge", int'(note_valid), 0);
      end
    join
    line(1'b1, 50);

    // fill FIFO, fifth code overflows
    rdy_mode = 0;
    line(1'b1, 2);
    foreach (digs[i]) send_frame(8'(8'h30 + digs[i]), 1'b1);
    line(1'b1, 20);
    check("full_valid", int'(note_valid), 1);
    check("full_depth", exp_notes.size(), DEPTH);
    check("full_head", int'(note), exp_notes[0]);
    rdy_mode = 1;
    line(1'b1, 20);
    check("drained_valid", int'(note_valid), 0);
    check("drained_queue", exp_notes.size(), 0);

    // out-of-range codes
    send_frame(8'h41, 1'b1);
    send_frame(8'h38, 1'b1);
    line(1'b1, 20);
    check("code_err_no_valid", int'(note_valid), 0);
    check("code_err_seen", exp_errs.size(), 0);

    // framing error with held break, then a good frame
    send_frame(8'h34, 1'b0);
    line(1'b0, 300);
    line(1'b1, 20);
    send_frame(8'h36, 1'b1);
    line(1'b1, 20);
    check("frame_err_seen", exp_errs.size(), 0);
    check("after_break_note", exp_notes.size(), 0);

    // short start glitch is ignored
    line(1'b0, 20);
    line(1'b1, 300);
    check("glitch_no_note", int'(note_valid), 0);

`ifdef UART_RX_MAJORITY_EN
    // 1-cycle spike at bit-2 centre of 0x35 must not corrupt the byte
    expect_frame(8'h35, 1'b1);
    b = 8'h35;
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        line(b[i], 52);
        line(~b[i], 1);
        line(b[i], 51);
      end else begin
        line(b[i], CPB);
      end
    end
    line(1'b1, CPB);
    line(1'b1, 20);
    check("majority_note", exp_notes.size(), 0);
`endif

    // reset mid-frame with two entries held
    rdy_mode = 0;
    send_frame(8'h32, 1'b1);
    send_frame(8'h34, 1'b1);
    line(1'b1, 20);
    check("pre_rst_valid", int'(note_valid), 1);
    line(1'b0, CPB);
    line(1'b0, CPB);
    line(1'b1, CPB);
    line(1'b0, 50);
    #2 rst = 1'b1;
    #1;
    check("midrst_note_valid", int'(note_valid), 0);
    check("midrst_note", int'(note), 0);
    check("midrst_errs", int'(frame_err) + int'(code_err) + int'(overflow), 0);
    exp_notes.delete();
    exp_errs.delete();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    line(1'b1, 20);
    send_frame(8'h35, 1'b1);
    line(1'b1, 20);
    check("post_rst_valid", int'(note_valid), 1);
    check("post_rst_note", int'(note), 5);
    rdy_mode = 1;
    line(1'b1, 5);
    check("post_rst_sole", int'(note_valid), 0);

    // randomized mix of digits, arbitrary bytes and framing errors
    rdy_mode = 2;
    repeat (25) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        b  = 8'(8'h30 + $urandom_range(0, 7));
        st = 1'b1;
      end else if (r < 85) begin
        b  = 8'($urandom);
        st = 1'b1;
      end else begin
        b  = 8'($urandom);
        st = 1'b0;
      end
      send_frame(b, st);
      if (!st) line(1'b0, $urandom_range(0, 50));
      line(1'b1, st ? $urandom_range(0, 20) : $urandom_range(5, 20));
    end

    rdy_mode = 1;
    line(1'b1, 50);
    check("final_notes_empty", exp_notes.size(), 0);
    check("final_errs_empty", exp_errs.size(), 0);
    check("final_valid", int'(note_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_note_rx.md
# uart_note_rx

Receive side of the button-to-note UART link. Deserialises 8N1 frames at 115200 baud from a 12 MHz clock and validates ASCII digits '0'..'7' (0x30..0x37). Each valid digit becomes a 3-bit button/note code, buffered in a small FIFO. The FIFO feeds the synthesiser's note-selection logic through a valid/ready handshake. Framing errors, out-of-range codes and FIFO overflow are flagged as single-cycle pulses.

## Interface
- CLK_FREQ, 12_000_000: clock frequency in Hz.
- BAUD, 115_200: line rate. CPB = CLK_FREQ/BAUD = 104, integer division. HALF = CPB/2 = 52.
- FIFO_DEPTH, 4: entries. Must be a power of two, ≥2.

- clk  in  1  system clock, 12 MHz onboard oscillator.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- note  out  3  FIFO head code (byte[2:0]). Valid only while note_valid=1.
- note_valid  out  1  FIFO non-empty.
- note_ready  in  1  consumer accepts head when note_valid & note_ready at posedge.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- code_err  out  1  one-cycle pulse when a well-framed byte is outside 0x30..0x37.
- overflow  out  1  one-cycle pulse when a valid code is dropped because the FIFO is full.

## Operation
- rx passes through a 2-FF synchroniser (rx_s). The synchroniser resets to 1.
- FSM states and transitions:
  - IDLE: cnt=0. rx_s==0 → START.
  - START: counts to HALF-1. Samples there. Sample 0 → DATA, cnt=0, bit=0. Sample 1 → IDLE, treated as a glitch with no error.
  - DATA: each time cnt==CPB-1, samples into shift[bit]. Order is LSB first. Sets cnt=0 and increments bit. After bit 7 → STOP.
  - STOP: samples at cnt==CPB-1.
    - 1 → byte complete, decode, → IDLE.
    - 0 → frame_err pulse, byte discarded, → BREAK.
  - BREAK: waits for rx_s==1, then → IDLE.
- Decode happens on the STOP sample cycle with stop=1:
  - byte[7:3]==5'b00110 → push byte[2:0].
  - Otherwise → code_err pulse, no push.
- FIFO is first-word-fall-through.
  - Push when not full → stored.
  - Push when full with no simultaneous pop → dropped, overflow pulse, contents unchanged.
  - Push when full with a simultaneous pop → accepted. Occupancy stays full.
  - Pop when empty → ignored.
  - Pointers wrap modulo FIFO_DEPTH. A count of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- note_ready is sampled only when note_valid=1.
- At most one of frame_err, code_err, overflow pulses per frame.

## Timing
- Reset values:
  - FSM=IDLE, cnt=0, bit=0, shift=0, rx sync regs=1.
  - FIFO empty; note_valid=0, note=0.
  - frame_err=code_err=overflow=0.
- Reset is asynchronous and may assert mid-frame. The partial byte is discarded and FIFO contents are lost. After release the FSM waits in IDLE for the next falling edge. A line already low at release starts a frame immediately; this behaviour is accepted.
- Start sample is HALF cycles after the falling edge, plus 2 synchroniser cycles. Subsequent samples fall every CPB cycles, near mid-bit.
- Stop-sample to FIFO write: the write occurs on the same clock edge as the decision. note_valid rises on the next edge (1 cycle). note reflects the new head on that same edge.
- Error pulses are registered and high for exactly one cycle, the cycle after the decision edge.
- Back-to-back frames: the next start edge may occur on the cycle after the STOP sample. IDLE detects it with no lost frame.
- Max sustained throughput: 1 code per 10·CPB cycles.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each sample (start, data, stop) is the 2-of-3 majority of rx_s at cnt = S-2, S-1, S, where S is the nominal sample count.
  - The decision is still made at S, so latency is unchanged.
  - Start glitches up to 1 cycle wide inside the window are rejected.
- Not defined: single sample of rx_s at S.

## Test plan
- Send 0x33 at 115200 with note_ready=1 → note_valid high 1 cycle after stop sample, note=3'd3, popped the next edge, no error pulses.
- note_ready=0, send '1','2','5','7','0' back-to-back → FIFO holds 1,2,5,7. overflow pulses once, on the fifth frame. Then raise note_ready → drains 1,2,5,7 in order, note_valid falls after 4 pops.
- Send 0x41 ('A'), then 0x38 → two code_err pulses, note_valid stays 0.
- Send 0x34 with stop bit forced 0, hold rx low 300 cycles, release, send 0x36 → one frame_err, no push for 0x34, then note=6 valid.
- Drive a 20-cycle low glitch on idle rx → FSM returns to IDLE from START, no pulses, no push. With UART_RX_MAJORITY_EN, a 1-cycle low pulse at a data bit centre does not flip the received bit.
- Assert rst mid-DATA of 0x32 with the FIFO holding 2 entries → all outputs zero immediately. After release, the next frame 0x35 yields note=5 as the sole entry.
